// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU data-memory bridge.
//   bridge_state_t : bridge FSM state encoding (IDLE, ISSUE, DONE)
//   TIMEOUT_RDATA  : load data returned to the CPU when an access is aborted
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } bridge_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog counter for a pending memory access.
// Ports:
//   clk     : sole clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : restart counting from zero (held while no access is pending)
//   enable  : one cycle spent waiting for the memory
//   expired : combinational, high in the LIMIT-th consecutive enabled cycle
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the number of enabled cycles already completed, so the
    // LIMIT-th waiting cycle is the one where count_q reaches LIMIT-1.
    assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges a single-cycle CPU data-memory port onto a valid/ready memory bus.
// The CPU is stalled from the request cycle until the memory completes; the
// result is presented in DONE, on whose closing edge the CPU advances.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_mem_read, cpu_mem_write     : CPU load / store request (both = store)
//   cpu_addr, cpu_wdata, cpu_rdata  : CPU address, store data, load data
//   cpu_stall                       : hold the CPU pipeline
//   mem_valid, mem_ready            : memory-side handshake
//   mem_we, mem_addr, mem_wdata     : memory-side command (word aligned)
//   mem_rdata                       : memory-side load data
//   bus_err                         : one-cycle pulse on an aborted access
// Build option: define DATA_MEM_BRIDGE_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles in ISSUE without mem_ready; otherwise ISSUE waits
// forever and bus_err stays 0.
module data_mem_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              bus_err
);

    bridge_state_t     state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic              we_q,      we_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic              bus_err_q, bus_err_d;

    logic cpu_req;
    logic in_issue;
    logic expired;

    assign cpu_req  = cpu_mem_read | cpu_mem_write;
    assign in_issue = (state_q == ISSUE);

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    // Clearing whenever we are outside ISSUE restarts the count on entry.
    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_issue),
        .enable  (in_issue && !mem_ready),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_mem_write;   // read+write collapses to a write
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // mem_ready is checked first so a completion in the expiry
                // cycle is still a normal completion.
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (expired) begin
                    if (!we_q) begin
                        rdata_d = TIMEOUT_RDATA;
                    end
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign cpu_stall = ((state_q == IDLE) && cpu_req) || in_issue;
    assign cpu_rdata = rdata_q;
    assign mem_valid = in_issue;
    assign mem_we    = in_issue && we_q;
    assign mem_addr  = addr_q & ~ADDR_W'(3);   // byte offset is ignored
    assign mem_wdata = wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_data_mem_bridge;

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 4;
`else
    localparam int unsigned TO_CYCLES = 255;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_bridge #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .ADDR_W         (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held;
        int errs;

        reset         = 1'b1;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        mem_ready     = 1'b0;
        mem_rdata     = '0;

        // ---- reset state
        tick(); tick();
        samp();
        check("rst_valid", mem_valid, 1'b0);
        check("rst_we",    mem_we,    1'b0);
        check("rst_addr",  mem_addr,  32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_err",   bus_err,   1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        tick(); reset = 1'b0;

        // ---- stray mem_ready in IDLE is ignored
        tick(); mem_ready = 1'b1;
        samp();
        check("idle_rdy_valid", mem_valid, 1'b0);
        check("idle_rdy_stall", cpu_stall, 1'b0);
        tick(); mem_ready = 1'b0;
        samp();
        check("idle_rdy_valid2", mem_valid, 1'b0);
        $display("txn idle mem_ready ignored");

        // ---- load, ready in first ISSUE cycle, unaligned address
        tick(); cpu_mem_read = 1'b1; cpu_addr = 32'h0000_00ff;
        samp();
        check("ld_req_stall", cpu_stall, 1'b1);
        check("ld_req_valid", mem_valid, 1'b0);
        tick(); mem_ready = 1'b1; mem_rdata = 32'hffff_ffff;
        samp();
        check("ld_iss_valid", mem_valid, 1'b1);
        check("ld_iss_addr",  mem_addr,  32'h0000_00fc);
        check("ld_iss_we",    mem_we,    1'b0);
        check("ld_iss_stall", cpu_stall, 1'b1);
        tick(); mem_ready = 1'b0; mem_rdata = 32'h0;
        samp();
        check("ld_done_stall", cpu_stall, 1'b0);
        check("ld_done_valid", mem_valid, 1'b0);
        check("ld_done_rdata", cpu_rdata, 32'hffff_ffff);
        tick(); cpu_mem_read = 1'b0;
        samp();
        check("ld_idle_stall", cpu_stall, 1'b0);
        check("ld_idle_valid", mem_valid, 1'b0);
        check("ld_idle_rdata", cpu_rdata, 32'hffff_ffff);
        $display("txn load addr=000000ff rdata=%h", cpu_rdata);

        // ---- store, ready delayed to 4th ISSUE cycle
        tick(); cpu_mem_write = 1'b1; cpu_addr = 32'd10; cpu_wdata = 32'd7;
        mem_rdata = 32'hdead_beef;
        samp();
        check("st_req_stall", cpu_stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); mem_ready = (i == 3);
            samp();
            check("st_iss_valid", mem_valid, 1'b1);
            check("st_iss_we",    mem_we,    1'b1);
            check("st_iss_wdata", mem_wdata, 32'd7);
            check("st_iss_addr",  mem_addr,  32'd8);
            check("st_iss_stall", cpu_stall, 1'b1);
        end
        tick(); mem_ready = 1'b0;
        samp();
        check("st_done_stall", cpu_stall, 1'b0);
        check("st_done_valid", mem_valid, 1'b0);
        check("st_done_rdata", cpu_rdata, 32'hffff_ffff);
        check("st_done_err",   bus_err,   1'b0);
        tick(); cpu_mem_write = 1'b0;
        $display("txn store addr=0000000a wdata=00000007");

        // ---- read and write together behave as a write
        tick(); cpu_mem_read = 1'b1; cpu_mem_write = 1'b1;
        cpu_addr = 32'h23; cpu_wdata = 32'h55;
        samp();
        check("rw_req_stall", cpu_stall, 1'b1);
        tick(); mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        samp();
        check("rw_iss_we",    mem_we,    1'b1);
        check("rw_iss_addr",  mem_addr,  32'h20);
        check("rw_iss_wdata", mem_wdata, 32'h55);
        tick(); mem_ready = 1'b0;
        samp();
        check("rw_done_rdata", cpu_rdata, 32'hffff_ffff);
        tick(); cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        $display("txn read+write addr=00000023 treated as store");

        // ---- reset in the second ISSUE cycle
        tick(); cpu_mem_read = 1'b1; cpu_addr = 32'h44;
        samp();
        tick(); mem_ready = 1'b0;
        samp();
        check("rs_iss1_valid", mem_valid, 1'b1);
        tick(); reset = 1'b1;
        samp();
        check("rs_iss2_valid", mem_valid, 1'b1);
        tick(); reset = 1'b0; cpu_mem_read = 1'b0;
        samp();
        check("rs_after_valid", mem_valid, 1'b0);
        check("rs_after_stall", cpu_stall, 1'b0);
        check("rs_after_err",   bus_err,   1'b0);
        check("rs_after_rdata", cpu_rdata, 32'h0);
        tick();
        samp();
        check("rs_after_err2",  bus_err,   1'b0);
        $display("txn reset during ISSUE abandoned");

        // ---- preload a non-zero read value
        tick(); cpu_mem_read = 1'b1; cpu_addr = 32'h100;
        tick(); mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick(); mem_ready = 1'b0;
        samp();
        check("pre_rdata", cpu_rdata, 32'h1111_2222);
        tick(); cpu_mem_read = 1'b0;
        $display("txn load addr=00000100 rdata=%h", cpu_rdata);

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
        // ---- timeout: memory never answers
        tick(); cpu_mem_read = 1'b1; cpu_addr = 32'h80;
        samp();
        for (int i = 0; i < 4; i++) begin
            tick(); mem_ready = 1'b0;
            samp();
            check("to_iss_valid", mem_valid, 1'b1);
            check("to_iss_err",   bus_err,   1'b0);
        end
        tick();
        samp();
        check("to_done_err",   bus_err,   1'b1);
        check("to_done_valid", mem_valid, 1'b0);
        check("to_done_rdata", cpu_rdata, 32'h0);
        check("to_done_stall", cpu_stall, 1'b0);
        tick(); cpu_mem_read = 1'b0;
        samp();
        check("to_idle_err",   bus_err,   1'b0);
        check("to_idle_stall", cpu_stall, 1'b0);
        check("to_idle_valid", mem_valid, 1'b0);
        $display("txn load addr=00000080 aborted by timeout");
`else
        // ---- no timeout: ready withheld for 300 cycles
        tick(); cpu_mem_read = 1'b1; cpu_addr = 32'h84;
        samp();
        held = 0;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            tick(); mem_ready = 1'b0;
            samp();
            if (mem_valid === 1'b1) held++;
            if (bus_err !== 1'b0) errs++;
        end
        check("hold_cycles", held, 32'd300);
        check("hold_errs",   errs, 32'd0);
        tick(); mem_ready = 1'b1; mem_rdata = 32'hcafe_f00d;
        samp();
        check("hold_last_valid", mem_valid, 1'b1);
        tick(); mem_ready = 1'b0;
        samp();
        check("hold_done_rdata", cpu_rdata, 32'hcafe_f00d);
        check("hold_done_err",   bus_err,   1'b0);
        check("hold_done_stall", cpu_stall, 1'b0);
        tick(); cpu_mem_read = 1'b0;
        $display("txn load addr=00000084 after 300 wait cycles rdata=%h", cpu_rdata);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles in ISSUE without mem_ready before abort.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_mem_read  input  1  CPU load request.
REQ-006 cpu_mem_write  input  1  CPU store request (CPU mem_write).
REQ-007 cpu_addr  input  ADDR_W  CPU data_memory_addr.
REQ-008 cpu_wdata  input  32  CPU write_data.
REQ-009 cpu_rdata  output  32  load data returned to CPU read_data.
REQ-010 cpu_stall  output  1  CPU holds PC and register writes while high.
REQ-011 mem_valid  output  1  memory-side request valid.
REQ-012 mem_ready  input  1  memory-side accept/complete strobe.
REQ-013 mem_we  output  1  memory-side write enable.
REQ-014 mem_addr  output  ADDR_W  word-aligned memory address.
REQ-015 mem_wdata  output  32  memory-side store data.
REQ-016 mem_rdata  input  32  memory-side load data, sampled when mem_valid & mem_ready.
REQ-017 bus_err  output  1  one-cycle pulse on aborted access.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DONE.
REQ-019 IDLE: on cpu_mem_read|cpu_mem_write, SHALL latch addr, wdata, we (= cpu_mem_write) and go to ISSUE next cycle.
REQ-020 cpu_stall SHALL equal (IDLE & (cpu_mem_read|cpu_mem_write)) | ISSUE, combinationally; low in DONE.
REQ-021 ISSUE: mem_valid SHALL be 1; mem_we/mem_addr/mem_wdata SHALL come from latched values and stay stable until handshake.
REQ-022 mem_addr SHALL be {latched_addr[ADDR_W-1:2], 2'b00}; low address bits ignored.
REQ-023 ISSUE with mem_ready=1: on that edge, reads SHALL capture mem_rdata into rdata_q, writes leave rdata_q unchanged; go to DONE.
REQ-024 Minimum access latency: request cycle + one ISSUE cycle + DONE = CPU advances on the edge ending DONE (3 cycles if mem_ready high in first ISSUE cycle).
REQ-025 DONE: cpu_rdata SHALL present rdata_q, mem_valid 0; next state IDLE unconditionally.
REQ-026 cpu_rdata SHALL hold rdata_q in all states.
REQ-027 Read and write both asserted: SHALL be treated as a write.
REQ-028 Requests arriving in ISSUE or DONE SHALL be ignored (CPU is stalled or advancing); a new request is accepted only in IDLE.
REQ-029 mem_ready while not in ISSUE SHALL be ignored.

Reset
REQ-030 reset SHALL force state IDLE, mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata_q 0, timeout counter 0, bus_err 0 on the next rising edge.
REQ-031 Reset during ISSUE SHALL abandon the access without bus_err; mem_valid low from the cycle after the reset edge.

Configuration
REQ-032 Macro DATA_MEM_BRIDGE_TIMEOUT_EN defined: counter increments each ISSUE cycle without mem_ready; reaching TIMEOUT_CYCLES SHALL drop mem_valid, set rdata_q to 0 (reads), pulse bus_err for one cycle, and go to DONE.
REQ-033 Counter SHALL clear on entry to ISSUE; mem_ready in the same cycle as expiry SHALL win (normal completion, no bus_err).
REQ-034 Macro undefined: no counter, ISSUE waits indefinitely, bus_err tied to 0.

Structure
REQ-035 State enum bridge_state_t and constant TIMEOUT_RDATA (32'h0) SHALL live in shared package mem_bus_pkg.
REQ-036 Timeout logic SHALL be sub-module bus_timeout_counter (inputs clk, reset, clear, enable; output expired), instantiated only under DATA_MEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-037 Load, mem_ready high first ISSUE cycle, cpu_addr 32'h000000ff, mem_rdata 32'hffffffff -> mem_addr 32'h000000fc, stall 2 cycles, cpu_rdata 32'hffffffff in DONE.
REQ-038 Store cpu_addr 10, cpu_wdata 7, mem_ready delayed 4 cycles -> mem_valid/mem_we/mem_wdata=7/mem_addr=8 stable 4 cycles, stall low only in DONE.
REQ-039 Read and write asserted together -> mem_we 1, rdata_q unchanged from prior load value.
REQ-040 Macro defined, TIMEOUT_CYCLES 4, mem_ready never -> bus_err pulse after 4 ISSUE cycles, cpu_rdata 0, back to IDLE.
REQ-041 Reset asserted on 2nd ISSUE cycle -> mem_valid 0 next cycle, state IDLE, bus_err 0, cpu_rdata 0.
REQ-042 Macro undefined, mem_ready withheld 300 cycles -> mem_valid held 300 cycles, no bus_err, completes normally.
